// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data request, grant and memory-port signals of mem_port_arbiter
interface mem_port_arbiter_if #(parameter int ADR_W = 32, parameter int DATA_W = 32);
  logic                  IReq_F;
  logic [ADR_W-1:0]      IAdr_F;
  logic                  IGrant;
  logic                  IValid;
  logic                  DReq_C;
  logic                  DWrite_C;
  logic [ADR_W-1:0]      DAdr_C;
  logic [DATA_W-1:0]     DWData_C;
  logic [DATA_W/8-1:0]   DByteEn_C;
  logic                  DGrant;
  logic                  DValid;
  logic [DATA_W-1:0]     RData;
  logic                  MemReq;
  logic                  MemWrite;
  logic [ADR_W-1:0]      MemAdr;
  logic [DATA_W-1:0]     MemWData;
  logic [DATA_W/8-1:0]   MemByteEn;
  logic                  MemReady;
  logic                  MemRValid;
  logic [DATA_W-1:0]     MemRData;
  logic                  StallFetch;
  logic                  StallData;
  modport slave (
    input  IReq_F, IAdr_F, DReq_C, DWrite_C, DAdr_C, DWData_C, DByteEn_C, MemReady, MemRValid, MemRData,
    output IGrant, IValid, DGrant, DValid, RData, MemReq, MemWrite, MemAdr, MemWData, MemByteEn, StallFetch, StallData
  );
  modport master (
    output IReq_F, IAdr_F, DReq_C, DWrite_C, DAdr_C, DWData_C, DByteEn_C, MemReady, MemRValid, MemRData,
    input  IGrant, IValid, DGrant, DValid, RData, MemReq, MemWrite, MemAdr, MemWData, MemByteEn, StallFetch, StallData
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-outstanding fetch/data arbiter onto one memory port; ARB_STARVATION_GUARD_EN adds fetch anti-starvation.
module mem_port_arbiter #(
  parameter int ADR_W    = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, I_REQ, D_REQ, I_WAIT, D_WAIT} state_t;
  state_t state_q, state_d;
  logic fetch_pri, sel_i, req;
`ifdef ARB_STARVATION_GUARD_EN
  localparam int CW = $clog2(MAX_WAIT + 1) < 3 ? 3 : $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign fetch_pri = bus.IReq_F && (!bus.DReq_C || cnt_q == CW'(MAX_WAIT));
  // counts IDLE arbitrations lost by a waiting fetch, saturating at MAX_WAIT
  assign cnt_d = (!bus.IReq_F || bus.IGrant) ? '0 :
                 (state_q == IDLE && req && !sel_i && cnt_q != CW'(MAX_WAIT)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign fetch_pri = bus.IReq_F && !bus.DReq_C && (MAX_WAIT >= 0);
`endif
  always_comb begin
    sel_i = state_q == I_REQ || (state_q == IDLE && fetch_pri);
    req = state_q == IDLE ? (bus.IReq_F || bus.DReq_C) :
          state_q == I_REQ ? bus.IReq_F : (state_q == D_REQ && bus.DReq_C);
    state_d = (state_q == IDLE || state_q == I_REQ || state_q == D_REQ) ?
              (!req ? IDLE : bus.MemReady ? (sel_i ? I_WAIT : D_WAIT) : (sel_i ? I_REQ : D_REQ)) :
              (bus.MemRValid ? IDLE : state_q);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  assign bus.MemReq     = !reset && req;
  assign bus.MemWrite   = bus.MemReq && !sel_i && bus.DWrite_C;
  assign bus.MemAdr     = bus.MemReq ? (sel_i ? bus.IAdr_F : bus.DAdr_C) : ADR_W'(0);
  assign bus.MemWData   = (bus.MemReq && !sel_i) ? bus.DWData_C : DATA_W'(0);
  assign bus.MemByteEn  = (bus.MemReq && !sel_i) ? bus.DByteEn_C : (DATA_W/8)'(0);
  assign bus.IGrant     = bus.MemReq && bus.MemReady && sel_i;
  assign bus.DGrant     = bus.MemReq && bus.MemReady && !sel_i;
  assign bus.IValid     = state_q == I_WAIT && bus.MemRValid;
  assign bus.DValid     = state_q == D_WAIT && bus.MemRValid;
  assign bus.RData      = bus.MemRData;
  assign bus.StallFetch = !reset && bus.IReq_F && !bus.IValid;
  assign bus.StallData  = !reset && bus.DReq_C && !bus.DValid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed literal scenarios plus randomized traffic checked against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int MAX_WAIT = 4;
`ifdef ARB_STARVATION_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  mem_port_arbiter_if #(.ADR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter #(.ADR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // model: an accepted transaction awaiting its response, or a presented but unaccepted request
  bit m_out, m_oi, m_lock, m_li;
  int m_cnt;
  wire [7:0] ctl = {bus.MemReq, bus.MemWrite, bus.IGrant, bus.DGrant, bus.IValid, bus.DValid, bus.StallFetch, bus.StallData};

  always @(negedge clk) begin : model
    logic ei, er, eiv, edv, idle;
    chk("rdata", bus.RData, bus.MemRData);
    if (reset) begin
      chk("reset_ctl", ctl, 8'h0);
      chk("reset_fields", {bus.MemAdr, bus.MemWData, bus.MemByteEn}, 0);
      m_out = 0; m_lock = 0; m_cnt = 0;
    end else begin
      ei = 0; er = 0; eiv = 0; edv = 0;
      idle = !m_out && !m_lock;
      if (m_out) begin
        eiv = m_oi && bus.MemRValid;
        edv = !m_oi && bus.MemRValid;
      end else begin
        ei = m_lock ? m_li : bus.IReq_F && (!bus.DReq_C || (GUARD && m_cnt == MAX_WAIT));
        er = ei ? bus.IReq_F : bus.DReq_C;
      end
      chk("ctl", ctl, {er, er && !ei && bus.DWrite_C, er && bus.MemReady && ei, er && bus.MemReady && !ei,
                       eiv, edv, bus.IReq_F && !eiv, bus.DReq_C && !edv});
      if (er) chk("memadr", bus.MemAdr, ei ? bus.IAdr_F : bus.DAdr_C);
      if (er && !ei) chk("wdata_be", {bus.MemWData, bus.MemByteEn}, {bus.DWData_C, bus.DByteEn_C});
      if (er && ei) chk("fetch_be", bus.MemByteEn, 0);
      if (!bus.IReq_F || (er && ei && bus.MemReady)) m_cnt = 0;
      else if (idle && er && !ei && m_cnt < MAX_WAIT) m_cnt++;
      if (m_out) begin
        if (bus.MemRValid) m_out = 0;
      end else if (er && bus.MemReady) begin
        m_out = 1; m_oi = ei; m_lock = 0;
      end else if (er) begin
        m_lock = 1; m_li = ei;
      end else m_lock = 0;
    end
  end

  task automatic quiet();
    bus.IReq_F = 0; bus.IAdr_F = 0; bus.DReq_C = 0; bus.DWrite_C = 0; bus.DAdr_C = 0;
    bus.DWData_C = 0; bus.DByteEn_C = 0; bus.MemReady = 0; bus.MemRValid = 0; bus.MemRData = 0;
  endtask

  initial begin
    int arb, first;
    quiet();
    reset = 1;
    bus.IReq_F = 1; bus.DReq_C = 1;
    @(negedge clk);
    chk("reset_memreq", bus.MemReq, 0);
    chk("reset_stall", {bus.StallFetch, bus.StallData}, 0);
    cyc(); reset = 0; quiet();
    @(negedge clk);
    chk("idle_memreq", bus.MemReq, 0);
    // fetch only, one-cycle memory
    cyc(); bus.IReq_F = 1; bus.IAdr_F = 32'h100; bus.MemReady = 1;
    @(negedge clk);
    chk("f_igrant", bus.IGrant, 1); chk("f_stall0", bus.StallFetch, 1); chk("f_adr", bus.MemAdr, 32'h100);
    cyc(); bus.IReq_F = 0; bus.MemRValid = 1; bus.MemRData = 32'h13;
    @(negedge clk);
    chk("f_ivalid", bus.IValid, 1); chk("f_rdata", bus.RData, 32'h13); chk("f_stall1", bus.StallFetch, 0);
    // simultaneous requests: data store first
    cyc(); bus.MemRValid = 0; bus.IReq_F = 1; bus.DReq_C = 1; bus.DWrite_C = 1; bus.DAdr_C = 32'h200;
    bus.DWData_C = 32'hDEADBEEF; bus.DByteEn_C = 4'hF;
    @(negedge clk);
    chk("s_write", bus.MemWrite, 1); chk("s_adr", bus.MemAdr, 32'h200); chk("s_dgrant", bus.DGrant, 1);
    chk("s_igrant0", bus.IGrant, 0); chk("s_wdata", bus.MemWData, 32'hDEADBEEF);
    cyc();
    @(negedge clk);
    chk("s_wait_req", bus.MemReq, 0);
    cyc(); bus.MemRValid = 1; bus.DReq_C = 0;
    @(negedge clk);
    chk("s_dvalid", bus.DValid, 1); chk("s_igrant1", bus.IGrant, 0);
    cyc(); bus.MemRValid = 0;
    @(negedge clk);
    chk("s_igrant2", bus.IGrant, 1); chk("s_fadr", bus.MemAdr, 32'h100); chk("s_fwrite", bus.MemWrite, 0);
    cyc(); bus.MemRValid = 1; bus.IReq_F = 0;
    @(negedge clk);
    chk("s_ivalid", bus.IValid, 1);
    // backpressure while fetch is locked
    cyc(); quiet(); bus.IReq_F = 1; bus.IAdr_F = 32'h300;
    @(negedge clk);
    chk("b_req", bus.MemReq, 1); chk("b_igrant0", bus.IGrant, 0);
    cyc(); bus.DReq_C = 1; bus.DAdr_C = 32'h400;
    @(negedge clk);
    chk("b_adr1", bus.MemAdr, 32'h300); chk("b_dgrant1", bus.DGrant, 0); chk("b_stalld", bus.StallData, 1);
    cyc();
    @(negedge clk);
    chk("b_adr2", bus.MemAdr, 32'h300);
    cyc(); bus.MemReady = 1;
    @(negedge clk);
    chk("b_igrant", bus.IGrant, 1); chk("b_dgrant3", bus.DGrant, 0);
    cyc();
    @(negedge clk);
    chk("b_wait", {bus.MemReq, bus.DGrant}, 0);
    cyc(); bus.MemRValid = 1; bus.IReq_F = 0;
    @(negedge clk);
    chk("b_ivalid", bus.IValid, 1); chk("b_dgrant5", bus.DGrant, 0);
    cyc(); bus.MemRValid = 0;
    @(negedge clk);
    chk("b_dgrant", bus.DGrant, 1); chk("b_dadr", bus.MemAdr, 32'h400);
    cyc(); bus.MemRValid = 1; bus.DReq_C = 0;
    @(negedge clk);
    chk("b_dvalid", bus.DValid, 1);
    // reset during D_WAIT, late response afterwards
    cyc(); quiet(); bus.DReq_C = 1; bus.DAdr_C = 32'h500; bus.MemReady = 1;
    @(negedge clk);
    chk("r_dgrant", bus.DGrant, 1);
    cyc(); reset = 1; bus.IReq_F = 1;
    @(negedge clk);
    chk("r_in_reset", {bus.MemReq, bus.DValid, bus.StallData}, 0);
    cyc(); reset = 0; bus.IReq_F = 0; bus.DReq_C = 0;
    @(negedge clk);
    chk("r_rel_req", bus.MemReq, 0);
    cyc(); bus.MemRValid = 1;
    @(negedge clk);
    chk("r_late_dvalid", bus.DValid, 0); chk("r_late_req", bus.MemReq, 0);
    cyc(); bus.MemRValid = 0; bus.DReq_C = 1;
    @(negedge clk);
    chk("r_new_dgrant", bus.DGrant, 1);
    cyc(); bus.MemRValid = 1; bus.DReq_C = 0;
    @(negedge clk);
    chk("r_new_dvalid", bus.DValid, 1);
    // starvation: continuous loads with a pending fetch
    cyc(); quiet(); reset = 1;
    cyc(); reset = 0; bus.IReq_F = 1; bus.DReq_C = 1; bus.MemReady = 1; bus.MemRValid = 1;
    arb = 0; first = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.MemReq) arb++;
      if (bus.IGrant && first == 0) first = arb;
      cyc();
    end
    chk("starve_first_fetch", first, GUARD ? 5 : 0);
    quiet();
    // randomized traffic
    repeat (3000) begin
      cyc();
      reset = $urandom_range(0, 99) == 0;
      bus.IReq_F = $urandom_range(0, 9) < 6; bus.IAdr_F = $urandom;
      bus.DReq_C = $urandom_range(0, 9) < 6; bus.DWrite_C = $urandom_range(0, 1) == 1;
      bus.DAdr_C = $urandom; bus.DWData_C = $urandom; bus.DByteEn_C = 4'($urandom);
      bus.MemReady = $urandom_range(0, 9) < 6; bus.MemRValid = $urandom_range(0, 1) == 1;
      bus.MemRData = $urandom;
    end
    cyc(); reset = 0; quiet();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
